ram_responder: RTL and testbench

- Memory-side responder for the cache controller's RAM request interface.
- Accepts single-cycle ram_req pulses carrying an address, plus a write flag and data for dirty write-backs.
- Services each request from an internal word array after a fixed, parameterised latency, then pulses ram_ready with read data.
- Serves as the behavioural main-memory model in cache system simulation and as a synthesizable on-chip backing store.

---
 rtl/ram_responder_pkg.sv | 27 ++
 rtl/ram_responder_if.sv | 54 +++++
 rtl/ram_responder_storage.sv | 47 ++++
 rtl/ram_responder.sv | 167 ++++++++++++++++
 tb/tb_ram_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
//
// Purpose : shared types and constants for the RAM responder slice.
//           Holds the responder FSM state encoding and the fixed widths of
//           the cache-controller RAM request interface.
//
// Contents:
//   RAM_WORD_W   width of one stored word / data bus (64)
//   RAM_ADDR_W   width of the byte address bus (32)
//   ram_state_t  responder FSM states: IDLE, WAIT, RESPOND
// ----------------------------------------------------------------------------
package ram_pkg;

   localparam int RAM_WORD_W = 64;
   localparam int RAM_ADDR_W = 32;

   // IDLE    : no request outstanding, ready to accept
   // WAIT    : request captured, counting down the access latency
   // RESPOND : ram_ready pulse cycle, write commits at the end of it
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } ram_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// ----------------------------------------------------------------------------
// ram_responder_if
//
// Purpose : bundles the cache-controller <-> main-memory request/response
//           signals so the initiator and the responder share one definition.
//
// Signals:
//   ram_req      initiator -> responder  single-cycle request strobe
//   ram_address  initiator -> responder  byte address of the request
//   ram_we       initiator -> responder  1 = write-back, 0 = line fill
//   ram_wdata    initiator -> responder  write-back data
//   ram_ready    responder -> initiator  one-cycle completion pulse
//   ram_in       responder -> initiator  read data, 0 outside ram_ready
//   busy         responder -> initiator  a request is outstanding
//   req_dropped  responder -> initiator  sticky: a request was ignored
//
// Modports:
//   master  the initiator (cache controller or testbench)
//   slave   the responder (ram_responder)
// ----------------------------------------------------------------------------
interface ram_responder_if;

   logic                            ram_req;
   logic [ram_pkg::RAM_ADDR_W-1:0]  ram_address;
   logic                            ram_we;
   logic [ram_pkg::RAM_WORD_W-1:0]  ram_wdata;
   logic                            ram_ready;
   logic [ram_pkg::RAM_WORD_W-1:0]  ram_in;
   logic                            busy;
   logic                            req_dropped;

   modport master (
      output ram_req,
      output ram_address,
      output ram_we,
      output ram_wdata,
      input  ram_ready,
      input  ram_in,
      input  busy,
      input  req_dropped
   );

   modport slave (
      input  ram_req,
      input  ram_address,
      input  ram_we,
      input  ram_wdata,
      output ram_ready,
      output ram_in,
      output busy,
      output req_dropped
   );

endinterface

// File: rtl/ram_responder_storage.sv
// ----------------------------------------------------------------------------
// ram_storage
//
// Purpose : the backing word array of the RAM responder. Contents are not
//           touched by reset, so data survives a responder reset.
//
// Parameters:
//   DEPTH   number of 64-bit words (power of two, >= 2)
//   IDX_W   word index width, derived from DEPTH
//
// Ports:
//   clk     input   rising-edge clock for the write port
//   we      input   write enable, data lands in the array at the clock edge
//   waddr   input   write word index
//   wdata   input   write data
//   raddr   input   read word index
//   rdata   output  combinational read data for raddr
// ----------------------------------------------------------------------------
module ram_storage
   import ram_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [RAM_WORD_W-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [RAM_WORD_W-1:0] rdata
);

   logic [RAM_WORD_W-1:0] mem [DEPTH];

   // Single synchronous write port; there is deliberately no reset here so
   // that a responder reset never disturbs stored data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read lets the responder present data in the same cycle it
   // enters RESPOND, and also sees a write committed on the previous edge.
   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// ----------------------------------------------------------------------------
// ram_responder
//
// Purpose : memory-side responder for the cache controller's RAM request
//           interface. Each accepted request is serviced from the internal
//           word array a fixed LATENCY cycles after the request cycle, with
//           a single ram_ready pulse. Usable both as a behavioural main
//           memory in simulation and as a synthesizable backing store.
//
// Parameters:
//   DEPTH     number of 64-bit words (power of two, >= 2)
//   LATENCY   request cycle to ram_ready cycle distance (>= 1)
//   ADDR_LSB  byte-offset bits dropped from the address to form the index
//
// Ports:
//   clk          input   system clock, rising edge
//   rst          input   synchronous reset, active-low
//   bus          slave   ram_responder_if (request/response bus + status)
//   read_count   output  [RAM_RESPONDER_STATS_EN only] completed reads
//   write_count  output  [RAM_RESPONDER_STATS_EN only] completed writes
//
// Configuration:
//   RAM_RESPONDER_STATS_EN  when defined, adds the read/write completion
//                           counters; all other behaviour is unchanged.
// ----------------------------------------------------------------------------
module ram_responder
   import ram_pkg::*;
#(
   parameter int DEPTH    = 1024,
   parameter int LATENCY  = 4,
   parameter int ADDR_LSB = 3
) (
   input  logic        clk,
   input  logic        rst,
   ram_responder_if.slave bus
`ifdef RAM_RESPONDER_STATS_EN
   ,
   output logic [31:0] read_count,
   output logic [31:0] write_count
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   ram_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      cur_idx;
   logic                  cur_we;
   logic [RAM_WORD_W-1:0] cur_wdata;
   logic                  ready_q;
   logic                  busy_q;
   logic                  dropped_q;

   logic [IDX_W-1:0]      req_idx;
   logic                  accept;
   logic                  mem_we;
   logic [RAM_WORD_W-1:0] rd_data;

   // Upper address bits are simply not looked at, so addresses beyond the
   // array wrap onto it.
   assign req_idx = bus.ram_address[ADDR_LSB +: IDX_W];

   // A request is taken when idle, and also in the RESPOND cycle so an
   // initiator can chain a line fill straight after its write-back.
   assign accept = bus.ram_req && ((state == IDLE) || (state == RESPOND));

   // The captured write lands in the array on the edge that ends RESPOND;
   // a reset on that same edge aborts it.
   assign mem_we = (state == RESPOND) && cur_we && rst;

   ram_storage #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_storage (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cur_idx),
      .wdata (cur_wdata),
      .raddr (cur_idx),
      .rdata (rd_data)
   );

   // Request FSM. ram_ready is registered alongside the state so it is high
   // exactly in RESPOND. The countdown is loaded with LATENCY-1 on accept;
   // WAIT hands over to RESPOND once the count has reached 1, which puts
   // ram_ready LATENCY cycles after the request cycle. Requests seen in WAIT
   // are ignored but leave the sticky req_dropped flag behind.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_idx   <= '0;
         cur_we    <= 1'b0;
         cur_wdata <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (accept) begin
            cur_idx   <= req_idx;
            cur_we    <= bus.ram_we;
            cur_wdata <= bus.ram_wdata;
            cnt       <= CNT_LOAD;
            busy_q    <= 1'b1;
            if (LATENCY == 1) begin
               state   <= RESPOND;
               ready_q <= 1'b1;
            end else begin
               state <= WAIT;
            end
         end else begin
            case (state)
               IDLE: begin
                  busy_q <= 1'b0;
               end
               WAIT: begin
                  if (bus.ram_req) begin
                     dropped_q <= 1'b1;
                  end
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_LAST) begin
                     state   <= RESPOND;
                     ready_q <= 1'b1;
                  end
               end
               RESPOND: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Read data is only driven during the ready pulse of a read; writes and
   // every other cycle present zero.
   assign bus.ram_ready   = ready_q;
   assign bus.ram_in      = (ready_q && !cur_we) ? rd_data : '0;
   assign bus.busy        = busy_q;
   assign bus.req_dropped = dropped_q;

`ifdef RAM_RESPONDER_STATS_EN
   // Completion counters step once per ram_ready pulse, split by the kind
   // of request that completed, and wrap naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         read_count  <= '0;
         write_count <= '0;
      end else if (state == RESPOND) begin
         if (cur_we) begin
            write_count <= write_count + 32'd1;
         end else begin
            read_count <= read_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_ram_responder
//
// Purpose : directed bench for ram_responder. One instance runs with
//           LATENCY=4 (main behaviour), a second with LATENCY=1 (chained
//           back-to-back traffic). Both share clk and rst.
// ----------------------------------------------------------------------------
module tb_ram_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   ram_responder_if bus4 ();
   ram_responder_if bus1 ();

`ifdef RAM_RESPONDER_STATS_EN
   logic [31:0] rc4, wc4, rc1, wc1;
`endif

   ram_responder #(.DEPTH(1024), .LATENCY(4), .ADDR_LSB(3)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus4)
`ifdef RAM_RESPONDER_STATS_EN
      ,
      .read_count  (rc4),
      .write_count (wc4)
`endif
   );

   ram_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_LSB(3)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus1)
`ifdef RAM_RESPONDER_STATS_EN
      ,
      .read_count  (rc1),
      .write_count (wc1)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic req, input logic [31:0] addr,
                         input logic we, input logic [63:0] wd);
      bus4.ram_req     = req;
      bus4.ram_address = addr;
      bus4.ram_we      = we;
      bus4.ram_wdata   = wd;
   endtask

   task automatic drive1(input logic req, input logic [31:0] addr,
                         input logic we, input logic [63:0] wd);
      bus1.ram_req     = req;
      bus1.ram_address = addr;
      bus1.ram_we      = we;
      bus1.ram_wdata   = wd;
   endtask

   // Full LATENCY=4 write, returns one cycle after its RESPOND cycle.
   task automatic write4(input logic [31:0] addr, input logic [63:0] wd);
      drive4(1'b1, addr, 1'b1, wd);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      repeat (4) next_cycle();
   endtask

   task automatic test_reset();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      drive1(1'b0, 32'h0, 1'b0, 64'h0);
      rst = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus4.ram_ready !== 1'b0) begin
         $display("[TB] FAIL reset_ready: got %b expected 0", bus4.ram_ready);
         tests_failed++;
      end
      tests_run++;
      if (bus4.ram_in !== 64'h0) begin
         $display("[TB] FAIL reset_ram_in: got %h expected 0", bus4.ram_in);
         tests_failed++;
      end
      tests_run++;
      if (bus4.busy !== 1'b0 || bus1.busy !== 1'b0) begin
         $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", bus4.busy, bus1.busy);
         tests_failed++;
      end
      tests_run++;
      if (bus4.req_dropped !== 1'b0) begin
         $display("[TB] FAIL reset_dropped: got %b expected 0", bus4.req_dropped);
         tests_failed++;
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   // Read of 0x28 (word 5): ready and data only in cycle N+4, busy N+1..N+4.
   task automatic test_latency();
      write4(32'h28, 64'hDEAD_BEEF_0000_0001);
      write4(32'h00, 64'h0000_0000_A5A5_A5A5);
      write4(32'h08, 64'h0808_0808_0808_0808);
      drive4(1'b1, 32'h28, 1'b0, 64'h0);
      @(negedge clk);
      tests_run++;
      if (bus4.busy !== 1'b0) begin
         $display("[TB] FAIL latency_busy_c0: got %b expected 0", bus4.busy);
         tests_failed++;
      end
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      for (int k = 1; k <= 6; k++) begin
         logic        exp_ready;
         logic [63:0] exp_data;
         logic        exp_busy;
         exp_ready = (k == 4);
         exp_data  = (k == 4) ? 64'hDEAD_BEEF_0000_0001 : 64'h0;
         exp_busy  = (k <= 4);
         @(negedge clk);
         tests_run++;
         if (bus4.ram_ready !== exp_ready || bus4.ram_in !== exp_data ||
             bus4.busy !== exp_busy) begin
            $display("[TB] FAIL latency_c%0d: got ready=%b data=%h busy=%b expected ready=%b data=%h busy=%b",
                     k, bus4.ram_ready, bus4.ram_in, bus4.busy, exp_ready, exp_data, exp_busy);
            tests_failed++;
         end
         next_cycle();
      end
   endtask

   // Write 0x1234 to 0x40, read 0x40 issued in the write's RESPOND cycle.
   task automatic test_back_to_back();
      drive4(1'b1, 32'h40, 1'b1, 64'h1234);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      repeat (3) next_cycle();
      drive4(1'b1, 32'h40, 1'b0, 64'h0);
      @(negedge clk);
      tests_run++;
      if (bus4.ram_ready !== 1'b1 || bus4.ram_in !== 64'h0) begin
         $display("[TB] FAIL b2b_write_resp: got ready=%b data=%h expected ready=1 data=0",
                  bus4.ram_ready, bus4.ram_in);
         tests_failed++;
      end
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      for (int k = 1; k <= 5; k++) begin
         logic        exp_ready;
         logic [63:0] exp_data;
         logic        exp_busy;
         exp_ready = (k == 4);
         exp_data  = (k == 4) ? 64'h1234 : 64'h0;
         exp_busy  = (k <= 4);
         @(negedge clk);
         tests_run++;
         if (bus4.ram_ready !== exp_ready || bus4.ram_in !== exp_data ||
             bus4.busy !== exp_busy) begin
            $display("[TB] FAIL b2b_read_c%0d: got ready=%b data=%h busy=%b expected ready=%b data=%h busy=%b",
                     k, bus4.ram_ready, bus4.ram_in, bus4.busy, exp_ready, exp_data, exp_busy);
            tests_failed++;
         end
         next_cycle();
      end
      tests_run++;
      if (bus4.req_dropped !== 1'b0) begin
         $display("[TB] FAIL b2b_dropped: got %b expected 0", bus4.req_dropped);
         tests_failed++;
      end
   endtask

   // 0x2000 wraps onto word 0 with DEPTH=1024.
   task automatic test_alias();
      drive4(1'b1, 32'h2000, 1'b0, 64'h0);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      repeat (3) next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus4.ram_ready !== 1'b1 || bus4.ram_in !== 64'h0000_0000_A5A5_A5A5) begin
         $display("[TB] FAIL alias_read: got ready=%b data=%h expected ready=1 data=00000000a5a5a5a5",
                  bus4.ram_ready, bus4.ram_in);
         tests_failed++;
      end
      next_cycle();
   endtask

   // Second request during WAIT is ignored and latches req_dropped.
   task automatic test_drop();
      int pulses;
      pulses = 0;
      drive4(1'b1, 32'h28, 1'b0, 64'h0);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      next_cycle();
      drive4(1'b1, 32'h40, 1'b1, 64'hBAD);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus4.ram_ready === 1'b1) pulses++;
         if (k == 1) begin
            tests_run++;
            if (bus4.ram_ready !== 1'b1 || bus4.ram_in !== 64'hDEAD_BEEF_0000_0001) begin
               $display("[TB] FAIL drop_first_resp: got ready=%b data=%h expected ready=1 data=deadbeef00000001",
                        bus4.ram_ready, bus4.ram_in);
               tests_failed++;
            end
         end
         next_cycle();
      end
      tests_run++;
      if (pulses != 1) begin
         $display("[TB] FAIL drop_pulses: got %0d expected 1", pulses);
         tests_failed++;
      end
      tests_run++;
      if (bus4.req_dropped !== 1'b1) begin
         $display("[TB] FAIL drop_flag: got %b expected 1", bus4.req_dropped);
         tests_failed++;
      end
      // Dropped write must not have landed: 0x40 still holds 0x1234.
      drive4(1'b1, 32'h40, 1'b0, 64'h0);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      repeat (3) next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus4.ram_in !== 64'h1234 || bus4.req_dropped !== 1'b1) begin
         $display("[TB] FAIL drop_nowrite: got data=%h dropped=%b expected data=1234 dropped=1",
                  bus4.ram_in, bus4.req_dropped);
         tests_failed++;
      end
      next_cycle();
   endtask

   // Reset two cycles after accepting a write aborts it.
   task automatic test_reset_abort();
      int pulses;
      int busy_seen;
      pulses    = 0;
      busy_seen = 0;
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus4.req_dropped !== 1'b0) begin
         $display("[TB] FAIL abort_dropped_clear: got %b expected 0", bus4.req_dropped);
         tests_failed++;
      end
      next_cycle();
      drive4(1'b1, 32'h08, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus4.ram_ready === 1'b1) pulses++;
         if (bus4.busy !== 1'b0) busy_seen++;
         next_cycle();
      end
      tests_run++;
      if (pulses != 0 || busy_seen != 0) begin
         $display("[TB] FAIL abort_quiet: got pulses=%0d busy_cycles=%0d expected 0/0", pulses, busy_seen);
         tests_failed++;
      end
      drive4(1'b1, 32'h08, 1'b0, 64'h0);
      next_cycle();
      drive4(1'b0, 32'h0, 1'b0, 64'h0);
      repeat (3) next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus4.ram_ready !== 1'b1 || bus4.ram_in !== 64'h0808_0808_0808_0808) begin
         $display("[TB] FAIL abort_old_value: got ready=%b data=%h expected ready=1 data=0808080808080808",
                  bus4.ram_ready, bus4.ram_in);
         tests_failed++;
      end
      next_cycle();
   endtask

   // LATENCY=1: three chained writes, then three chained reads; the first
   // read targets the word being written in the same cycle.
   task automatic test_latency_one();
      logic        req_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] addr_t [8] = '{32'h10, 32'h18, 32'h20, 32'h20, 32'h10, 32'h18, 32'h0, 32'h0};
      logic        we_t   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [63:0] wd_t   [8] = '{64'h11, 64'h22, 64'h33, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
      logic        rdy_t  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [63:0] dat_t  [8] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h33, 64'h11, 64'h22, 64'h0};
      for (int i = 0; i < 8; i++) begin
         drive1(req_t[i], addr_t[i], we_t[i], wd_t[i]);
         @(negedge clk);
         tests_run++;
         if (bus1.ram_ready !== rdy_t[i] || bus1.ram_in !== dat_t[i] ||
             bus1.busy !== rdy_t[i]) begin
            $display("[TB] FAIL lat1_c%0d: got ready=%b data=%h busy=%b expected ready=%b data=%h busy=%b",
                     i, bus1.ram_ready, bus1.ram_in, bus1.busy, rdy_t[i], dat_t[i], rdy_t[i]);
            tests_failed++;
         end
         next_cycle();
      end
      tests_run++;
      if (bus1.req_dropped !== 1'b0) begin
         $display("[TB] FAIL lat1_dropped: got %b expected 0", bus1.req_dropped);
         tests_failed++;
      end
`ifdef RAM_RESPONDER_STATS_EN
      tests_run++;
      if (rc1 !== 32'd3 || wc1 !== 32'd3) begin
         $display("[TB] FAIL lat1_stats: got reads=%0d writes=%0d expected 3/3", rc1, wc1);
         tests_failed++;
      end
`endif
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_alias();
      test_drop();
      test_reset_abort();
      test_latency_one();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Guards against a stalled run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
